// File: rtl/eqv_seq_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : eqv_seq_pkg
//  Purpose  : Shared definitions for the equivalence-check sequencer:
//             the FSM state encoding and the vector-counter width helper.
//  Ports    : none (package)
//  Revision : 1.0 - initial release
// ============================================================================
package eqv_seq_pkg;

    localparam logic [1:0] C_ST_IDLE    = 2'd0;
    localparam logic [1:0] C_ST_SETTLE  = 2'd1;
    localparam logic [1:0] C_ST_COMPARE = 2'd2;
    localparam logic [1:0] C_ST_DONE    = 2'd3;

    typedef enum logic [1:0] {
        ST_IDLE    = C_ST_IDLE,
        ST_SETTLE  = C_ST_SETTLE,
        ST_COMPARE = C_ST_COMPARE,
        ST_DONE    = C_ST_DONE
    } state_e;

    // One bit wider than the vector so the final vector is never confused
    // with a wrapped counter.
    function automatic int cnt_width(input int n_in);
        return n_in + 1;
    endfunction

endpackage : eqv_seq_pkg
`default_nettype wire

// File: rtl/eqv_settle_timer.sv
`default_nettype none
// ============================================================================
//  Module   : eqv_settle_timer
//  Purpose  : Loadable down-counter that measures how long a vector has been
//             held. Loading presets SETTLE-1; tc_o is high once it reaches 0,
//             so tc_o rises in the SETTLE-th cycle after a load.
//  Ports    : clk    - clock, rising edge
//             rst_n  - synchronous active-low reset
//             load_i - preset counter to SETTLE-1 (has priority)
//             en_i   - decrement while non-zero
//             tc_o   - terminal count (counter == 0)
//  Revision : 1.0 - initial release
// ============================================================================
module eqv_settle_timer #(
    parameter int SETTLE = 1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic load_i,
    input  logic en_i,
    output logic tc_o
);

    localparam int          C_W    = (SETTLE < 1) ? 1 : $clog2(SETTLE + 1);
    localparam logic [C_W-1:0] C_LOAD = C_W'(SETTLE - 1);

    logic [C_W-1:0] cnt_q;
    logic [C_W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = C_LOAD;
        end else if (en_i && (cnt_q != '0)) begin
            cnt_d = cnt_q - C_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign tc_o = (cnt_q == '0);

endmodule : eqv_settle_timer
`default_nettype wire

// File: rtl/eqv_check_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : eqv_check_sequencer
//  Purpose  : Exhaustive equivalence-check driver. Drives every input vector
//             (ascending) into circuits A and B, holds it SETTLE cycles, then
//             compares the outputs. Reports sat (outputs differ somewhere)
//             and the first counterexample vector.
//  Ports    : clk, rst_n       - clock / synchronous active-low reset
//             start            - begin a run (honoured only when idle)
//             vec   [N_IN]     - vector driven to both circuits
//             a_out/b_out      - circuit outputs [N_OUT]
//             busy, done       - run in progress / one-cycle completion pulse
//             sat, cex [N_IN]  - mismatch flag / first mismatching vector
//             mis_cnt [N_IN+1] - mismatch count (EQV_SEQ_COUNT_ALL_EN only)
//  Config   : EQV_SEQ_COUNT_ALL_EN - scan all vectors, count mismatches
//  Revision : 1.0 - initial release
// ============================================================================
module eqv_check_sequencer
    import eqv_seq_pkg::*;
#(
    parameter int N_IN   = 2,
    parameter int N_OUT  = 1,
    parameter int SETTLE = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    output logic [N_IN-1:0]  vec,
    input  logic [N_OUT-1:0] a_out,
    input  logic [N_OUT-1:0] b_out,
    output logic             busy,
    output logic             done,
    output logic             sat,
`ifdef EQV_SEQ_COUNT_ALL_EN
    output logic [N_IN:0]    mis_cnt,
`endif
    output logic [N_IN-1:0]  cex
);

    localparam int            CW     = cnt_width(N_IN);
    localparam logic [CW-1:0] C_LAST = {1'b0, {N_IN{1'b1}}};

    state_e          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [N_IN-1:0] cex_q, cex_d;
    logic            tmr_load, tmr_en, tmr_tc;
    logic            mis;

`ifdef EQV_SEQ_COUNT_ALL_EN
    localparam logic [N_IN:0] C_MIS_MAX = {1'b1, {N_IN{1'b0}}};
    logic [N_IN:0]   mis_cnt_q, mis_cnt_d;
`else
    logic            sat_q, sat_d;
`endif

    assign mis = (a_out != b_out);

    eqv_settle_timer #(
        .SETTLE (SETTLE)
    ) u_timer (
        .clk    (clk),
        .rst_n  (rst_n),
        .load_i (tmr_load),
        .en_i   (tmr_en),
        .tc_o   (tmr_tc)
    );

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        cex_d    = cex_q;
        tmr_load = 1'b0;
        tmr_en   = 1'b0;
`ifdef EQV_SEQ_COUNT_ALL_EN
        mis_cnt_d = mis_cnt_q;
`else
        sat_d     = sat_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    cnt_d    = '0;
                    cex_d    = '0;
                    tmr_load = 1'b1;
`ifdef EQV_SEQ_COUNT_ALL_EN
                    mis_cnt_d = '0;
`else
                    sat_d     = 1'b0;
`endif
                    state_d  = ST_SETTLE;
                end
            end
            ST_SETTLE: begin
                tmr_en = 1'b1;
                if (tmr_tc) begin
                    state_d = ST_COMPARE;
                end
            end
            ST_COMPARE: begin
`ifdef EQV_SEQ_COUNT_ALL_EN
                if (mis) begin
                    // Only the first mismatch is kept as the counterexample.
                    if (mis_cnt_q == '0) begin
                        cex_d = cnt_q[N_IN-1:0];
                    end
                    if (mis_cnt_q != C_MIS_MAX) begin
                        mis_cnt_d = mis_cnt_q + (N_IN+1)'(1);
                    end
                end
                if (cnt_q == C_LAST) begin
                    state_d = ST_DONE;
                end else begin
                    cnt_d    = cnt_q + CW'(1);
                    tmr_load = 1'b1;
                    state_d  = ST_SETTLE;
                end
`else
                if (mis) begin
                    sat_d   = 1'b1;
                    cex_d   = cnt_q[N_IN-1:0];
                    state_d = ST_DONE;
                end else if (cnt_q == C_LAST) begin
                    state_d = ST_DONE;
                end else begin
                    cnt_d    = cnt_q + CW'(1);
                    tmr_load = 1'b1;
                    state_d  = ST_SETTLE;
                end
`endif
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            cex_q   <= '0;
`ifdef EQV_SEQ_COUNT_ALL_EN
            mis_cnt_q <= '0;
`else
            sat_q     <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            cex_q   <= cex_d;
`ifdef EQV_SEQ_COUNT_ALL_EN
            mis_cnt_q <= mis_cnt_d;
`else
            sat_q     <= sat_d;
`endif
        end
    end

    assign vec  = cnt_q[N_IN-1:0];
    assign busy = (state_q != ST_IDLE);
    assign done = (state_q == ST_DONE);
    assign cex  = cex_q;
`ifdef EQV_SEQ_COUNT_ALL_EN
    assign mis_cnt = mis_cnt_q;
    assign sat     = (mis_cnt_q != '0);
`else
    assign sat     = sat_q;
`endif

endmodule : eqv_check_sequencer
`default_nettype wire
